spk_out_fifo: RTL

SPK_OUT_FIFO -- requirements
Module: spk_out_fifo

---
 rtl/spk_out_fifo.sv | 120 ++++++++++++
 1 files changed

// File: rtl/spk_out_fifo.sv
// spk_out_fifo: adds a per-field destination offset to each spike id, buffers the words in a FIFO
// and presents them through a valid/ready output register. Optional drop counter: SPK_OUT_DROP_CNT_EN.
module spk_out_fifo #(
  parameter int SW        = 24,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          soma_spk_vld,
  input  logic [SW-1:0] config_spk_out_neuid,
  input  logic [SW-1:0] dst_offset,
  output logic          spk_out_config_full,
  output logic          spk_out_vld,
  output logic [SW-1:0] spk_out_data,
  input  logic          spk_out_rdy,
  output logic          spk_out_empty,
  output logic          spk_out_drop
`ifdef SPK_OUT_DROP_CNT_EN
  ,
  input  logic          drop_cnt_clr,
  output logic [15:0]   drop_cnt
`endif
);

  localparam int FW = SW / 3;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] MARGIN_C = CW'(AF_MARGIN);

  typedef enum logic {ST_EMPTY = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] data_q, data_d;
  logic          pop;
  logic          wr_en;

  // Each {z,y,x} field wraps on its own; no carry crosses a field boundary.
  function automatic logic [SW-1:0] add_fields(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < 3; i++) r[i*FW +: FW] = a[i*FW +: FW] + b[i*FW +: FW];
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    spk_out_vld = (state_q == ST_HOLD);
    case (state_q)
      ST_EMPTY: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (spk_out_rdy) begin
          if (count_q != '0) pop = 1'b1;
          else state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // A pop frees the head slot in the same cycle, so a full FIFO still accepts a write then.
  always_comb begin
    wr_en    = soma_spk_vld && ((count_q != DEPTH_C) || pop);
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    data_d   = pop ? mem_q[rd_ptr_q] : data_q;
    count_d  = count_q;
    if (wr_en && !pop) count_d = count_q + CW'(1);
    else if (!wr_en && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= add_fields(config_spk_out_neuid, dst_offset);
  end

  assign spk_out_data        = data_q;
  assign spk_out_empty       = (count_q == '0) && (state_q == ST_EMPTY);
  assign spk_out_config_full = (DEPTH_C - count_q) <= MARGIN_C;
  assign spk_out_drop        = soma_spk_vld && !wr_en;

`ifdef SPK_OUT_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else if (drop_cnt_clr) drop_cnt_q <= '0;
    else if (spk_out_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
